wb_stage: RTL and testbench

Writeback stage of the five-stage RV32I pipeline. Holds the MEM/WB pipeline register, waits for data-memory load responses that may arrive late, aligns and sign/zero-extends load data, and drives the register-file write port (`writedata`, `write_rd`, `wb_RegWrite`) that the decode stage consumes for its register file and same-cycle bypass. Exerts backpressure on the MEM stage while a load response is outstanding.

---
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, late load-response wait, load alignment/extension, regfile write port.
// Optional 64-bit retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic        mem_RegWrite,
  input  logic        mem_MemToReg,
  input  logic [2:0]  mem_Mmask,
  input  logic [31:0] mem_alu_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] writedata,
  output logic [4:0]  write_rd,
  output logic        wb_RegWrite,
  output logic        wb_stall
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_count
`endif
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e      state_q;
  logic        v_q;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic [2:0]  mmask_q;
  logic [31:0] alu_q;

  logic        retiring;
  logic        capture;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;
  logic [31:0] load_data;

  // A load retires in the first cycle its response is present, which may be its first WB cycle.
  assign retiring  = v_q && (!memtoreg_q || dmem_rvalid);
  assign mem_ready = !v_q || retiring;
  assign capture   = mem_valid && mem_ready;
  assign wb_stall  = v_q && memtoreg_q && !dmem_rvalid;

  assign shifted = dmem_rdata >> {alu_q[1:0], 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign sext    = !mmask_q[2];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    load_data = dmem_rdata;
    case (mmask_q[1:0])
      2'b00:   load_data = {{24{ld_byte[7] & sext}}, ld_byte};
      2'b01:   load_data = {{16{ld_half[15] & sext}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  assign writedata   = memtoreg_q ? load_data : alu_q;
  assign write_rd    = rd_q;
  assign wb_RegWrite = retiring && regwrite_q && (rd_q != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v_q        <= 1'b0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      mmask_q    <= 3'b000;
      alu_q      <= 32'd0;
    end else begin
      state_q <= wb_stall ? WAIT_LOAD : IDLE;
      if (capture) begin
        v_q        <= 1'b1;
        rd_q       <= mem_rd;
        regwrite_q <= mem_RegWrite;
        memtoreg_q <= mem_MemToReg;
        mmask_q    <= mem_Mmask;
        alu_q      <= mem_alu_result;
      end else if (retiring) begin
        v_q <= 1'b0;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 64'd0;
    end else if (retiring) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected regfile writes, a negedge monitor pops and compares.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_RegWrite;
  logic        mem_MemToReg;
  logic [2:0]  mem_Mmask;
  logic [31:0] mem_alu_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] writedata;
  logic [4:0]  write_rd;
  logic        wb_RegWrite;
  logic        wb_stall;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks;
  int          failures;
  logic [63:0] exp_retire;

  localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010, MBU = 3'b100, MHU = 3'b101;

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_RegWrite   (mem_RegWrite),
    .mem_MemToReg   (mem_MemToReg),
    .mem_Mmask      (mem_Mmask),
    .mem_alu_result (mem_alu_result),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .writedata      (writedata),
    .write_rd       (write_rd),
    .wb_RegWrite    (wb_RegWrite),
    .wb_stall       (wb_stall)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef WB_RETIRE_CNT_EN
    check(name, retire_count, exp_retire);
`endif
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (wb_RegWrite) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual rd=%0d data=%h expected no write t=%0t",
                 write_rd, writedata, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_rd", {59'd0, write_rd}, {59'd0, e.rd});
        check("sb_data", {32'd0, writedata}, {32'd0, e.data});
      end
    end
  end

  // One instruction through WB; for loads the response arrives k cycles after the first WB cycle.
  task automatic run_op(input string name, input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic [2:0] mask, input logic [31:0] alu, input int k,
                        input logic [31:0] rdata, input logic [31:0] exp_data);
    logic exp_we;
    exp_we = rw && (rd != 5'd0);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = rd; mem_RegWrite = rw; mem_MemToReg = m2r;
    mem_Mmask = mask; mem_alu_result = alu;
    check({name, "_ready_in"}, {63'd0, mem_ready}, 64'd1);
    if (exp_we) sb.push_back('{rd: rd, data: exp_data});
    @(posedge clk); #1;
    mem_valid = 1'b0;
    if (m2r) begin
      for (int i = 0; i < k; i++) begin
        check({name, "_stall"}, {63'd0, wb_stall}, 64'd1);
        check({name, "_ready_stall"}, {63'd0, mem_ready}, 64'd0);
        check({name, "_we_stall"}, {63'd0, wb_RegWrite}, 64'd0);
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      #1;
    end
    check({name, "_nostall"}, {63'd0, wb_stall}, 64'd0);
    check({name, "_ready_ret"}, {63'd0, mem_ready}, 64'd1);
    check({name, "_we"}, {63'd0, wb_RegWrite}, {63'd0, exp_we});
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    exp_retire++;
    check({name, "_we_after"}, {63'd0, wb_RegWrite}, 64'd0);
    check_cnt({name, "_cnt"});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wdata"}, {32'd0, writedata}, 64'd0);
    check({name, "_wrd"}, {59'd0, write_rd}, 64'd0);
    check({name, "_we"}, {63'd0, wb_RegWrite}, 64'd0);
    check({name, "_stall"}, {63'd0, wb_stall}, 64'd0);
    check({name, "_ready"}, {63'd0, mem_ready}, 64'd1);
    check_cnt({name, "_cnt"});
  endtask

  initial begin
    checks = 0; failures = 0; exp_retire = 64'd0;
    rst_n = 1'b0; mem_valid = 1'b0; mem_rd = 5'd0; mem_RegWrite = 1'b0; mem_MemToReg = 1'b0;
    mem_Mmask = 3'b000; mem_alu_result = 32'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    //      name     rd     rw    m2r   mask alu            k  rdata          expected
    run_op("alu",    5'd5,  1'b1, 1'b0, MW,  32'h1234_5678, 0, 32'h0,         32'h1234_5678);
    run_op("lb3",    5'd6,  1'b1, 1'b1, MB,  32'h1000_0003, 0, 32'h80FF_0011, 32'hFFFF_FF80);
    run_op("lbu3",   5'd6,  1'b1, 1'b1, MBU, 32'h1000_0003, 0, 32'h80FF_0011, 32'h0000_0080);
    run_op("lh2",    5'd9,  1'b1, 1'b1, MH,  32'h2000_0002, 3, 32'h8001_7FFF, 32'hFFFF_8001);
    run_op("lhu1",   5'd10, 1'b1, 1'b1, MHU, 32'h2000_0001, 1, 32'h8001_7FFF, 32'h0000_7FFF);
    run_op("lh0",    5'd11, 1'b1, 1'b1, MH,  32'h2000_0000, 0, 32'h1234_8000, 32'hFFFF_8000);
    run_op("lb1",    5'd12, 1'b1, 1'b1, MB,  32'h2000_0001, 2, 32'h80FF_0011, 32'h0000_0000);
    run_op("lw1",    5'd13, 1'b1, 1'b1, MW,  32'h2000_0001, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    run_op("x0",     5'd0,  1'b1, 1'b0, MW,  32'hDEAD_BEEF, 0, 32'h0,         32'h0);
    run_op("nowr",   5'd14, 1'b0, 1'b1, MW,  32'h3000_0000, 1, 32'h1111_2222, 32'h0);

    // Four back-to-back ALU ops: accepted every cycle and written on consecutive cycles.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_RegWrite = 1'b1; mem_MemToReg = 1'b0;
      mem_Mmask = MW; mem_alu_result = 32'hA000_0000 + 32'(i);
      sb.push_back('{rd: 5'(20 + i), data: 32'hA000_0000 + 32'(i)});
      check("b2b_ready", {63'd0, mem_ready}, 64'd1);
      @(posedge clk); #1;
      exp_retire++;
      check("b2b_we", {63'd0, wb_RegWrite}, 64'd1);
      check("b2b_rd", {59'd0, write_rd}, {59'd0, 5'(20 + i)});
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_we_after", {63'd0, wb_RegWrite}, 64'd0);
    check_cnt("b2b_cnt");

    // Reset during WAIT_LOAD discards the entry; a later response is ignored.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_RegWrite = 1'b1; mem_MemToReg = 1'b1;
    mem_Mmask = MW; mem_alu_result = 32'h4000_0000;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_stall", {63'd0, wb_stall}, 64'd1);
    rst_n = 1'b0;
    exp_retire = 64'd0;
    #1;
    check_reset_outputs("rstw_in");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    check("rstw_late_we", {63'd0, wb_RegWrite}, 64'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    check_reset_outputs("rstw_after");

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
